ascon_block_sequencer: RTL and testbench
========================================

# ascon_block_sequencer

Multi-block sequencer between the USB register file and the Ascon-128 core. Host-written AD and plaintext blocks are buffered in a parametrised FIFO and fed to the core one block per `core_read` handshake. The block generates `valid`, `last`, `eot`, `key_valid` and `select` for arbitrary AD and message block counts. It replaces the fixed one-AD/one-message control FSM in the top level and runs on `usb_clk_buf`, which also clocks the core in this build.

## Interface
- `pDATA_WIDTH`, 128: block width in bits.
- `pDEPTH`, 8: FIFO depth in blocks; power of two, at least 2.
- `pVB_WIDTH`, 5: valid-bytes field width.
- `pCNT_WIDTH`, 8: width of the block-count fields.
- `usb_clk_buf`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `host_wr`  in  1  push-block strobe, one cycle per block.
- `host_data`  in  pDATA_WIDTH  block data.
- `host_vb`  in  pVB_WIDTH  valid bytes of the block, 0..16.
- `host_sel`  in  1  block type: 0 = AD, 1 = message.
- `host_full`  out  1  FIFO full.
- `host_count`  out  $clog2(pDEPTH)+1  FIFO occupancy.
- `start`  in  1  start-sequence pulse.
- `abort`  in  1  synchronous abort and flush.
- `ad_blocks`  in  pCNT_WIDTH  number of AD blocks; 0 is allowed.
- `msg_blocks`  in  pCNT_WIDTH  number of message blocks; must be at least 1.
- `core_data`  out  pDATA_WIDTH  head block to the core.
- `core_vb`  out  pVB_WIDTH  head valid bytes.
- `core_sel`  out  1  0 = AD, 1 = message (the data mux select).
- `core_valid`, `core_last`, `core_eot`, `core_key_valid`  out  1 each  core controls.
- `core_read`  in  1  core accepted the current block, one-cycle pulse.
- `core_ready_tag`  in  1  core tag available.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on tag completion.
- `err`  out  2  sticky errors: [0] phase/type mismatch, [1] overflow or bad config.

## Operation
- **FIFO**
  - Circular buffer of {sel, vb, data}, pDEPTH entries, with wrapping read and write pointers.
  - A push while full is dropped and sets err[1], unless a pop happens in the same cycle; in that case the push is accepted and the count is unchanged.
  - Simultaneous push and pop leaves the count unchanged.
  - `abort` empties the FIFO.
- **States:** IDLE, AD, MSG, WAIT_TAG, DONE.
- **IDLE**
  - `start` latches `ad_rem = ad_blocks` and `msg_rem = msg_blocks`, and clears `err`.
  - If `msg_blocks` = 0: set err[1] and stay in IDLE.
  - Otherwise go to AD if `ad_blocks` ≠ 0, else go to MSG.
  - `start` is ignored outside IDLE.
- **AD and MSG**
  - `core_valid` = FIFO not empty.
  - `core_sel` = 0 in AD, 1 in MSG.
  - `core_last` = (remaining count == 1).
  - `core_eot` = `core_last` in MSG, 0 in AD.
  - `core_data` and `core_vb` come from the FIFO head.
  - On `core_read` while `core_valid`: pop the head and decrement the remaining count.
  - When AD pops with `ad_rem` == 1, go to MSG. When MSG pops with `msg_rem` == 1, go to WAIT_TAG.
  - `core_read` while the FIFO is empty is ignored.
- **Type check:** if the head's `sel` ≠ the current phase while non-empty in AD or MSG, set err[0], flush the FIFO, and go to IDLE. No `core_valid` is issued for the bad entry.
- **WAIT_TAG and DONE**
  - `core_key_valid` = 1 in AD, MSG and WAIT_TAG; 0 in IDLE and DONE.
  - WAIT_TAG goes to DONE when `core_ready_tag` = 1; `done` pulses on that transition.
  - DONE goes to IDLE when `core_ready_tag` = 0.
- **Abort:** `abort` in any state forces IDLE and flushes the FIFO; `err` is kept. `abort` has priority over `start`, push and pop in the same cycle.

## Timing
- **Reset values:** every output is 0, the state is IDLE, pointers and count are 0, and `err` is 0.
- **FIFO latency:**
  - A push at edge N makes the entry visible at the head, with `host_count` updated, after edge N.
  - If the FIFO was empty and the state is AD or MSG, `core_valid` rises in the cycle after the push edge.
- **Start latency:** `start` at edge N gives AD/MSG state and `busy` = 1 after edge N. With the FIFO pre-loaded, `core_valid` = 1 in the same cycle.
- **Pop:** `core_read` sampled at edge N presents the next head, or drops `core_valid`, after edge N.
- **Boundaries:**
  - `host_full` = (count == pDEPTH).
  - Pointers wrap modulo pDEPTH.
  - Remaining-count arithmetic is pCNT_WIDTH wide and never decrements below 1 before the state exit.
- **Outputs:** `core_*` outputs are combinational from the state and FIFO registers only. There is no combinational path from `core_read` to any output.

## Test plan
- **Nominal transfer:** push 2 AD blocks (vb = 16) then 1 MSG block (vb = 5), `start` with ad = 2, msg = 1, core pulses `core_read` every 3 cycles.
  - Expect `core_last` only on AD #2; `core_eot` = 1 with `core_sel` = 1 and `core_vb` = 5; after `core_ready_tag`, `done` pulses once and `busy` falls when the tag drops.
- **No AD:** ad_blocks = 0, msg = 1.
  - Expect IDLE → MSG directly, no AD `core_valid`, and `core_key_valid` = 1 from the cycle after `start`.
- **Full FIFO:** fill pDEPTH = 8, then push a 9th block.
  - Expect `host_full` = 1, count = 8, err[1] = 1.
  - Then push and pop in the same cycle: count stays 8, the entry is accepted, and pointer wrap preserves order.
- **Bad config and type check:** `start` with msg_blocks = 0 gives err[1] and `busy` stays 0. Push an MSG block during the AD phase: err[0] = 1, FIFO count goes to 0, state returns to IDLE.
- **Abort and reset:** assert `abort` mid-MSG with 3 entries queued; the next cycle shows IDLE, count 0, `core_valid` 0. Assert `resetn` low mid-AD: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/ascon_block_sequencer.sv
// Multi-block sequencer feeding buffered AD/message blocks to the Ascon-128 core.
// A small FIFO holds host blocks; an FSM issues valid/last/eot/key_valid/select per block.
module ascon_block_sequencer #(
  parameter int pDATA_WIDTH = 128,
  parameter int pDEPTH      = 8,
  parameter int pVB_WIDTH   = 5,
  parameter int pCNT_WIDTH  = 8
) (
  input  logic                       usb_clk_buf,
  input  logic                       resetn,
  input  logic                       host_wr,
  input  logic [pDATA_WIDTH-1:0]     host_data,
  input  logic [pVB_WIDTH-1:0]       host_vb,
  input  logic                       host_sel,
  output logic                       host_full,
  output logic [$clog2(pDEPTH):0]    host_count,
  input  logic                       start,
  input  logic                       abort,
  input  logic [pCNT_WIDTH-1:0]      ad_blocks,
  input  logic [pCNT_WIDTH-1:0]      msg_blocks,
  output logic [pDATA_WIDTH-1:0]     core_data,
  output logic [pVB_WIDTH-1:0]       core_vb,
  output logic                       core_sel,
  output logic                       core_valid,
  output logic                       core_last,
  output logic                       core_eot,
  output logic                       core_key_valid,
  input  logic                       core_read,
  input  logic                       core_ready_tag,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int PTR_W   = $clog2(pDEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = pDATA_WIDTH + pVB_WIDTH + 1;

  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [OCC_W-1:0]      OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]      OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0]      OCC_FULL = OCC_W'(pDEPTH);
  localparam logic [pCNT_WIDTH-1:0] REM_ONE  = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] REM_ZERO = {pCNT_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AD       = 3'd1,
    ST_MSG      = 3'd2,
    ST_WAIT_TAG = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                  state_q;
  logic [pCNT_WIDTH-1:0]   ad_rem_q;
  logic [pCNT_WIDTH-1:0]   msg_rem_q;
  logic [1:0]              err_q;
  logic [1:0]              err_d;
  logic                    done_q;

  logic [ENTRY_W-1:0]      mem_q [pDEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        count_q, count_d;

  logic [ENTRY_W-1:0]      head_s;
  logic                    empty_s, full_s, in_phase_s, phase_sel_s, type_err_s;
  logic                    valid_s, pop_s, push_s, flush_s, ovf_s, start_s, bad_cfg_s;
  logic [pCNT_WIDTH-1:0]   rem_s;

  // Handshake decode; a head whose type disagrees with the phase is never offered to the core.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    empty_s     = (count_q == OCC_ZERO);
    full_s      = (count_q == OCC_FULL);
    in_phase_s  = (state_q == ST_AD) || (state_q == ST_MSG);
    phase_sel_s = (state_q == ST_MSG);
    rem_s       = phase_sel_s ? msg_rem_q : ad_rem_q;
    type_err_s  = in_phase_s && !empty_s && (head_s[ENTRY_W-1] != phase_sel_s);
    valid_s     = in_phase_s && !empty_s && !type_err_s;
    flush_s     = abort || type_err_s;
    pop_s       = valid_s && core_read && !abort;
    push_s      = host_wr && !flush_s && (!full_s || pop_s);
    ovf_s       = host_wr && !flush_s && full_s && !pop_s;
    start_s     = (state_q == ST_IDLE) && start && !abort;
    bad_cfg_s   = start_s && (msg_blocks == REM_ZERO);
  end

  // Errors are cleared by an accepted start, then any new fault in the same cycle is recorded.
  always_comb begin
    err_d    = start_s ? 2'b00 : err_q;
    err_d[1] = err_d[1] | ovf_s | bad_cfg_s;
    err_d[0] = err_d[0] | (type_err_s && !abort);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = OCC_ZERO;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + OCC_ONE;
        2'b01:   count_d = count_q - OCC_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage and pointers; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge usb_clk_buf or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < pDEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= OCC_ZERO;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {host_sel, host_vb, host_data};
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer FSM: remaining counts exit at 1 and are never decremented past it.
  always_ff @(posedge usb_clk_buf or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ad_rem_q  <= REM_ZERO;
      msg_rem_q <= REM_ZERO;
      err_q     <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              ad_rem_q  <= ad_blocks;
              msg_rem_q <= msg_blocks;
              if (msg_blocks != REM_ZERO) begin
                state_q <= (ad_blocks != REM_ZERO) ? ST_AD : ST_MSG;
              end
            end
          end
          ST_AD: begin
            if (type_err_s) begin
              state_q <= ST_IDLE;
            end else if (pop_s) begin
              if (ad_rem_q == REM_ONE) begin
                state_q <= ST_MSG;
              end else begin
                ad_rem_q <= ad_rem_q - REM_ONE;
              end
            end
          end
          ST_MSG: begin
            if (type_err_s) begin
              state_q <= ST_IDLE;
            end else if (pop_s) begin
              if (msg_rem_q == REM_ONE) begin
                state_q <= ST_WAIT_TAG;
              end else begin
                msg_rem_q <= msg_rem_q - REM_ONE;
              end
            end
          end
          ST_WAIT_TAG: begin
            if (core_ready_tag) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (!core_ready_tag) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_valid     = valid_s;
  assign core_data      = valid_s ? head_s[pDATA_WIDTH-1:0] : {pDATA_WIDTH{1'b0}};
  assign core_vb        = valid_s ? head_s[pDATA_WIDTH +: pVB_WIDTH] : {pVB_WIDTH{1'b0}};
  assign core_sel       = in_phase_s && phase_sel_s;
  assign core_last      = in_phase_s && (rem_s == REM_ONE);
  assign core_eot       = core_last && phase_sel_s;
  assign core_key_valid = in_phase_s || (state_q == ST_WAIT_TAG);
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign host_full      = full_s;
  assign host_count     = count_q;

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed plus randomized bench for ascon_block_sequencer, checked against a queue-based model.
module tb_ascon_block_sequencer;

  localparam int DW = 128;
  localparam int DEPTH = 8;
  localparam int VBW = 5;
  localparam int CW = 8;
  localparam int P_IDLE = 0, P_AD = 1, P_MSG = 2, P_WAIT = 3, P_DONE = 4;

  logic usb_clk_buf = 1'b0;
  logic resetn = 1'b0;
  logic host_wr = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic [VBW-1:0] host_vb = '0;
  logic host_sel = 1'b0;
  logic host_full;
  logic [$clog2(DEPTH):0] host_count;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CW-1:0] ad_blocks = '0;
  logic [CW-1:0] msg_blocks = '0;
  logic [DW-1:0] core_data;
  logic [VBW-1:0] core_vb;
  logic core_sel, core_valid, core_last, core_eot, core_key_valid;
  logic core_read = 1'b0;
  logic core_ready_tag = 1'b0;
  logic busy, done;
  logic [1:0] err;

  ascon_block_sequencer #(
    .pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pVB_WIDTH(VBW), .pCNT_WIDTH(CW)
  ) dut (
    .usb_clk_buf(usb_clk_buf), .resetn(resetn),
    .host_wr(host_wr), .host_data(host_data), .host_vb(host_vb), .host_sel(host_sel),
    .host_full(host_full), .host_count(host_count),
    .start(start), .abort(abort), .ad_blocks(ad_blocks), .msg_blocks(msg_blocks),
    .core_data(core_data), .core_vb(core_vb), .core_sel(core_sel),
    .core_valid(core_valid), .core_last(core_last), .core_eot(core_eot),
    .core_key_valid(core_key_valid), .core_read(core_read),
    .core_ready_tag(core_ready_tag), .busy(busy), .done(done), .err(err)
  );

  always #5 usb_clk_buf = ~usb_clk_buf;

  typedef struct packed {
    logic           sel;
    logic [VBW-1:0] vb;
    logic [DW-1:0]  data;
  } blk_t;

  // Reference model: a block queue plus the sequencing phase and remaining counts.
  blk_t          q_m[$];
  int            ph_m;
  int            ad_rem_m, msg_rem_m;
  logic [1:0]    err_m;
  logic          done_m;

  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    ph_m = P_IDLE;
    ad_rem_m = 0;
    msg_rem_m = 0;
    err_m = 2'b00;
    done_m = 1'b0;
  endtask

  function automatic bit model_type_err();
    bit inph = (ph_m == P_AD) || (ph_m == P_MSG);
    if (!inph || q_m.size() == 0) return 1'b0;
    return q_m[0].sel != (ph_m == P_MSG);
  endfunction

  function automatic bit model_valid();
    return ((ph_m == P_AD) || (ph_m == P_MSG)) && (q_m.size() > 0) && !model_type_err();
  endfunction

  task automatic check_outputs();
    bit inph = (ph_m == P_AD) || (ph_m == P_MSG);
    bit vld = model_valid();
    int rem = (ph_m == P_MSG) ? msg_rem_m : ad_rem_m;
    check("busy", DW'(busy), DW'(ph_m != P_IDLE));
    check("done", DW'(done), DW'(done_m));
    check("err", DW'(err), DW'(err_m));
    check("host_count", DW'(host_count), DW'(q_m.size()));
    check("host_full", DW'(host_full), DW'(q_m.size() == DEPTH));
    check("core_valid", DW'(core_valid), DW'(vld));
    check("core_key_valid", DW'(core_key_valid), DW'(inph || ph_m == P_WAIT));
    if (inph || ph_m == P_IDLE) begin
      check("core_sel", DW'(core_sel), DW'(ph_m == P_MSG));
      check("core_last", DW'(core_last), DW'(inph && rem == 1));
      check("core_eot", DW'(core_eot), DW'(ph_m == P_MSG && rem == 1));
    end
    if (vld) begin
      check("core_data", core_data, q_m[0].data);
      check("core_vb", DW'(core_vb), DW'(q_m[0].vb));
    end
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit terr = model_type_err();
    bit vld = model_valid();
    bit pop = vld && core_read;
    int old = ph_m;
    done_m = 1'b0;
    if (abort) begin
      q_m.delete();
      ph_m = P_IDLE;
      return;
    end
    if (old == P_IDLE && start) begin
      err_m = 2'b00;
      ad_rem_m = ad_blocks;
      msg_rem_m = msg_blocks;
      if (msg_blocks == 0) err_m[1] = 1'b1;
      else ph_m = (ad_blocks != 0) ? P_AD : P_MSG;
    end
    if (terr) begin
      err_m[0] = 1'b1;
      q_m.delete();
      ph_m = P_IDLE;
      return;
    end
    if (pop) begin
      void'(q_m.pop_front());
      if (old == P_AD) begin
        if (ad_rem_m == 1) ph_m = P_MSG; else ad_rem_m--;
      end else begin
        if (msg_rem_m == 1) ph_m = P_WAIT; else msg_rem_m--;
      end
    end
    if (host_wr) begin
      if (q_m.size() < DEPTH) q_m.push_back('{host_sel, host_vb, host_data});
      else err_m[1] = 1'b1;
    end
    if (old == P_WAIT && core_ready_tag) begin
      ph_m = P_DONE;
      done_m = 1'b1;
    end else if (old == P_DONE && !core_ready_tag) begin
      ph_m = P_IDLE;
    end
  endtask

  task automatic step();
    check_outputs();
    model_step();
    @(posedge usb_clk_buf);
    @(negedge usb_clk_buf);
  endtask

  task automatic idle_inputs();
    host_wr = 1'b0; start = 1'b0; abort = 1'b0; core_read = 1'b0; core_ready_tag = 1'b0;
  endtask

  task automatic push(input logic sel, input logic [VBW-1:0] vb);
    host_wr = 1'b1;
    host_sel = sel;
    host_vb = vb;
    host_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    host_wr = 1'b0;
  endtask

  task automatic do_start(input int ad, input int msg);
    ad_blocks = CW'(ad);
    msg_blocks = CW'(msg);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_tag(output int dones);
    dones = 0;
    core_read = 1'b0;
    core_ready_tag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    core_ready_tag = 1'b0;
    for (int i = 0; i < 2; i++) step();
  endtask

  initial begin
    int ad_lasts;
    int dones;
    model_reset();
    @(negedge usb_clk_buf);
    check_outputs();
    @(negedge usb_clk_buf);
    resetn = 1'b1;
    step();

    // Nominal transfer: 2 AD blocks then one short message block.
    push(1'b0, 5'd16);
    push(1'b0, 5'd16);
    push(1'b1, 5'd5);
    do_start(2, 1);
    ad_lasts = 0;
    for (int i = 0; i < 40 && ph_m != P_WAIT; i++) begin
      core_read = (i % 3 == 2);
      if (core_valid && core_read && core_last && !core_sel) ad_lasts++;
      step();
    end
    check("nominal_ad_last_count", DW'(ad_lasts), DW'(1));
    check("nominal_wait_key_valid", DW'(core_key_valid), DW'(1));
    finish_tag(dones);
    check("nominal_done_pulses", DW'(dones), DW'(1));
    check("nominal_busy_after_tag", DW'(busy), DW'(0));

    // No AD blocks: straight into the message phase.
    push(1'b1, 5'($urandom_range(0, 16)));
    do_start(0, 1);
    check("noad_key_valid", DW'(core_key_valid), DW'(1));
    check("noad_sel", DW'(core_sel), DW'(1));
    core_read = 1'b1;
    step();
    finish_tag(dones);
    check("noad_done_pulses", DW'(dones), DW'(1));

    // Fill, overflow, then push and pop together with wrapped pointers.
    for (int i = 0; i < DEPTH + 1; i++) push(1'b0, 5'($urandom_range(0, 16)));
    check("full_flag", DW'(host_full), DW'(1));
    check("full_err1", DW'(err[1]), DW'(1));
    do_start(20, 1);
    for (int i = 0; i < 5; i++) begin
      core_read = 1'b1;
      host_wr = 1'b1;
      host_sel = 1'b0;
      host_vb = 5'($urandom_range(0, 16));
      host_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      check("pushpop_count", DW'(host_count), DW'(DEPTH));
    end
    host_wr = 1'b0;
    for (int i = 0; i < DEPTH; i++) step();
    core_read = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Bad config, then a message block offered during the AD phase.
    do_start(1, 0);
    check("badcfg_busy", DW'(busy), DW'(0));
    check("badcfg_err1", DW'(err[1]), DW'(1));
    push(1'b1, 5'd3);
    do_start(1, 1);
    step();
    check("typeerr_count", DW'(host_count), DW'(0));
    check("typeerr_err0", DW'(err[0]), DW'(1));

    // Abort mid-message with three entries queued.
    for (int i = 0; i < 4; i++) push(1'b1, 5'd16);
    do_start(0, 5);
    core_read = 1'b1;
    step();
    core_read = 1'b0;
    check("abort_pre_count", DW'(host_count), DW'(3));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", DW'(core_valid), DW'(0));
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      host_wr = ($urandom_range(0, 2) == 0);
      host_sel = ($urandom_range(0, 5) == 0) ? 1'b1 : (ph_m == P_MSG);
      host_vb = 5'($urandom_range(0, 16));
      host_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      start = (ph_m == P_IDLE) && ($urandom_range(0, 3) == 0);
      ad_blocks = CW'($urandom_range(0, 2));
      msg_blocks = CW'($urandom_range(0, 3));
      core_read = ($urandom_range(0, 1) == 1);
      core_ready_tag = ($urandom_range(0, 1) == 1);
      abort = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset in the middle of the AD phase.
    for (int i = 0; i < 2; i++) push(1'b0, 5'd16);
    do_start(3, 1);
    check("prereset_busy", DW'(busy), DW'(1));
    resetn = 1'b0;
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_valid", DW'(core_valid), DW'(0));
    check("rst_key_valid", DW'(core_key_valid), DW'(0));
    check("rst_count", DW'(host_count), DW'(0));
    check("rst_err", DW'(err), DW'(0));
    check("rst_data", core_data, DW'(0));
    model_reset();
    @(negedge usb_clk_buf);
    resetn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
